// File: rtl/bulls_cows_core.sv
// bulls_cows_core
// Parametrised Bulls-and-Cows (xAyB) game controller. A secret code of
// NUM_DIGITS digits is entered (switches or LFSR), then guesses are entered
// digit by digit and scored as A (right digit, right place) and B (right
// digit, wrong place). The game ends in WIN on a full match or LOSE when
// chances run out; p0 from either end state starts a new game.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   p0_pulse        confirm/advance (one-cycle pulse)
//   p1_pulse        back/undo (one-cycle pulse)
//   sw_val/sw_valid switch digit and switch-entry-active flag
//   lfsr_val        random digit source used in SET when sw_valid=0
//   state           0 IDLE,1 SET,2 GUESS,3 SCORE,4 SHOW,5 WIN,6 LOSE
//   digit_idx       position being entered (NUM_DIGITS-1 first)
//   candidate       digit a p0 would commit this cycle
//   target/guess    packed codes, digit i at [i*DIGIT_W +: DIGIT_W]
//   is_random       per target digit: 1 = came from lfsr_val
//   chances         remaining wrong guesses
//   score_a/score_b bulls/cows of the last scored guess
//   score_valid     one-cycle pulse when score_a/score_b update
//   reject          one-cycle pulse when a p0 was refused
//
// Pulse semantics: p0_pulse and p1_pulse carry no handshake; each is a
// single-cycle request that is acted on (or refused via reject) in the cycle
// it is seen. p0 has priority: when both are high, p1 is dropped.
module bulls_cows_core #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int DIGIT_MAX   = 9,
  parameter int MAX_CHANCES = 5,
  parameter int ALLOW_DUP   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             p0_pulse,
  input  logic                             p1_pulse,
  input  logic [DIGIT_W-1:0]               sw_val,
  input  logic                             sw_valid,
  input  logic [DIGIT_W-1:0]               lfsr_val,
  output logic [2:0]                       state,
  output logic [$clog2(NUM_DIGITS)-1:0]    digit_idx,
  output logic [DIGIT_W-1:0]               candidate,
  output logic [NUM_DIGITS*DIGIT_W-1:0]    target,
  output logic [NUM_DIGITS*DIGIT_W-1:0]    guess,
  output logic [NUM_DIGITS-1:0]            is_random,
  output logic [$clog2(MAX_CHANCES+1)-1:0] chances,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  score_a,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  score_b,
  output logic                             score_valid,
  output logic                             reject
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(NUM_DIGITS+1);
  localparam int HW = $clog2(MAX_CHANCES+1);
  // Highest digit value that can actually appear in a DIGIT_W-bit field.
  localparam int VMAX = (DIGIT_MAX < (1 << DIGIT_W)) ? DIGIT_MAX : (1 << DIGIT_W) - 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [HW-1:0] FULL_CH   = HW'(MAX_CHANCES);
  localparam logic [CW-1:0] ALL_BULLS = CW'(NUM_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_GUESS = 3'd2,
    S_SCORE = 3'd3,
    S_SHOW  = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             digit_idx_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] target_q, guess_q;
  logic [NUM_DIGITS-1:0]     is_random_q;
  logic [HW-1:0]             chances_q;
  logic [CW-1:0]             score_a_q, score_b_q;
  logic                      score_valid_q, reject_q;

  logic                      dup_hit, cand_in_range, commit_ok;
  logic [CW-1:0]             bulls, cows, matched, cnt_g, cnt_t;

  // In SET a missing switch entry falls back to the random source.
  always_comb begin
    candidate = sw_val;
    if (state_q == S_SET && !sw_valid) candidate = lfsr_val;
  end

  // Digits are entered from the top index down, so the already-committed
  // digits of the current pass are exactly those above digit_idx. Lower
  // positions in guess may still hold the previous guess and are ignored.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i > int'(digit_idx_q)) begin
        if (state_q == S_SET) begin
          if (target_q[i*DIGIT_W +: DIGIT_W] == candidate) dup_hit = 1'b1;
        end else begin
          if (guess_q[i*DIGIT_W +: DIGIT_W] == candidate) dup_hit = 1'b1;
        end
      end
    end
  end

  assign cand_in_range = (int'(candidate) <= DIGIT_MAX);
  assign commit_ok = p0_pulse && cand_in_range &&
                     (state_q != S_GUESS || sw_valid) &&
                     (ALLOW_DUP != 0 || !dup_hit);

  // Scoring on the registered guess/target. With unique digits, cows are a
  // plain cross-position match count; with duplicates allowed, cows are the
  // per-value multiset overlap minus the bulls so no digit is counted twice.
  always_comb begin
    bulls   = '0;
    cows    = '0;
    matched = '0;
    cnt_g   = '0;
    cnt_t   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (guess_q[i*DIGIT_W +: DIGIT_W] == target_q[i*DIGIT_W +: DIGIT_W]) bulls = bulls + CW'(1);
    end
    if (ALLOW_DUP == 0) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        for (int j = 0; j < NUM_DIGITS; j++) begin
          if (i != j && guess_q[i*DIGIT_W +: DIGIT_W] == target_q[j*DIGIT_W +: DIGIT_W])
            cows = cows + CW'(1);
        end
      end
    end else begin
      for (int v = 0; v <= VMAX; v++) begin
        cnt_g = '0;
        cnt_t = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (guess_q[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(v))  cnt_g = cnt_g + CW'(1);
          if (target_q[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(v)) cnt_t = cnt_t + CW'(1);
        end
        matched = matched + ((cnt_g < cnt_t) ? cnt_g : cnt_t);
      end
      cows = matched - bulls;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (p0_pulse) state_d = S_SET;
      S_SET:   if (commit_ok && digit_idx_q == '0) state_d = S_GUESS;
      S_GUESS: if (commit_ok && digit_idx_q == '0) state_d = S_SCORE;
      S_SCORE: begin
        if (bulls == ALL_BULLS)          state_d = S_WIN;
        else if (chances_q <= HW'(1))    state_d = S_LOSE;
        else                             state_d = S_SHOW;
      end
      S_SHOW:  if (p0_pulse) state_d = S_GUESS;
      S_WIN,
      S_LOSE:  if (p0_pulse) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_idx_q   <= LAST_IDX;
      target_q      <= '0;
      guess_q       <= '0;
      is_random_q   <= '0;
      chances_q     <= FULL_CH;
      score_a_q     <= '0;
      score_b_q     <= '0;
      score_valid_q <= 1'b0;
      reject_q      <= 1'b0;
    end else begin
      score_valid_q <= 1'b0;
      reject_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (p0_pulse) begin
            digit_idx_q <= LAST_IDX;
            chances_q   <= FULL_CH;
            is_random_q <= '0;
            score_a_q   <= '0;
            score_b_q   <= '0;
          end
        end
        S_SET, S_GUESS: begin
          if (p0_pulse) begin
            if (commit_ok) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_idx_q == IW'(i)) begin
                  if (state_q == S_SET) begin
                    target_q[i*DIGIT_W +: DIGIT_W] <= candidate;
                    is_random_q[i]                 <= ~sw_valid;
                  end else begin
                    guess_q[i*DIGIT_W +: DIGIT_W]  <= candidate;
                  end
                end
              end
              if (digit_idx_q == '0) begin
                // SET wraps to the top for guessing; GUESS moves on to SCORE,
                // and SHOW reloads the index before the next guess.
                if (state_q == S_SET) digit_idx_q <= LAST_IDX;
              end else begin
                digit_idx_q <= digit_idx_q - IW'(1);
              end
            end else begin
              reject_q <= 1'b1;
            end
          end else if (p1_pulse && digit_idx_q != LAST_IDX) begin
            digit_idx_q <= digit_idx_q + IW'(1);
          end
        end
        S_SCORE: begin
          score_a_q     <= bulls;
          score_b_q     <= cows;
          score_valid_q <= 1'b1;
          if (bulls != ALL_BULLS && chances_q != '0) chances_q <= chances_q - HW'(1);
        end
        S_SHOW: begin
          if (p0_pulse) digit_idx_q <= LAST_IDX;
        end
        S_WIN, S_LOSE: begin
          if (p0_pulse) begin
            digit_idx_q <= LAST_IDX;
            target_q    <= '0;
            guess_q     <= '0;
            is_random_q <= '0;
            chances_q   <= FULL_CH;
            score_a_q   <= '0;
            score_b_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign digit_idx   = digit_idx_q;
  assign target      = target_q;
  assign guess       = guess_q;
  assign is_random   = is_random_q;
  assign chances     = chances_q;
  assign score_a     = score_a_q;
  assign score_b     = score_b_q;
  assign score_valid = score_valid_q;
  assign reject      = reject_q;

endmodule
